matmul_sequencer: RTL and testbench

Hardware sequencer that computes C = A × B for N×N integer matrices held in the shared data memory. It replaces the unrolled lw / multiply / add / store instruction stream with an FSM that generates the addresses, drives the data-memory port, accumulates the dot products and writes C back. It sits beside the data memory, and the single-cycle core's memory-side logic muxes it onto the memory port while `busy` is high.

---
 rtl/matmul_sequencer.sv | 155 +++++++++++++++
 tb/tb_matmul_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks i/j/k over two N x N row-major matrices in data memory,
// accumulates each dot product and writes C back, one memory access per cycle.
module matmul_sequencer #(
  parameter int N  = 3,
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_c,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] NA = AW'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StMac,
    StWr,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0] acc_q, acc_d, a_q, a_d;
  logic [AW-1:0] ba_q, ba_d, bb_q, bb_d, bc_q, bc_d;
  logic [DW-1:0] prod;

  // Row-major offsets; arithmetic is AW bits wide so addresses wrap naturally.
  logic [AW-1:0] off_ik, off_kj, off_ij;
  assign off_ik = AW'(i_q) * NA + AW'(k_q);
  assign off_kj = AW'(k_q) * NA + AW'(j_q);
  assign off_ij = AW'(i_q) * NA + AW'(j_q);

  // Low DW bits of the product; B's element arrives on mem_rdata during MAC.
  assign prod = a_q * mem_rdata;

  // Next-state, datapath updates and strobe decode.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_d       = a_q;
    ba_d      = ba_q;
    bb_d      = bb_q;
    bc_d      = bc_q;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ba_d    = base_a;
          bb_d    = base_b;
          bc_d    = base_c;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = StRdA;
        end
      end
      StRdA: begin
        mem_addr = ba_q + off_ik;
        mem_rd   = 1'b1;
        state_d  = StRdB;
      end
      StRdB: begin
        mem_addr = bb_q + off_kj;
        mem_rd   = 1'b1;
        a_d      = mem_rdata;
        state_d  = StMac;
      end
      StMac: begin
        acc_d = acc_q + prod;
        if (k_q != LAST) begin
          k_d     = k_q + 1'b1;
          state_d = StRdA;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        mem_addr  = bc_q + off_ij;
        mem_wr    = 1'b1;
        mem_wdata = acc_q;
        acc_d     = '0;
        k_d       = '0;
        state_d   = StRdA;
        if (j_q != LAST) begin
          j_d = j_q + 1'b1;
        end else begin
          j_d = '0;
          if (i_q != LAST) begin
            i_d = i_q + 1'b1;
          end else begin
            i_d     = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      ba_q    <= ba_d;
      bb_q    <= bb_d;
      bc_q    <= bc_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: behavioural memory plus a loop-level reference model.
module tb_matmul_sequencer;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int NN    = N * N;
  localparam int OPCYC = N * N * (3 * N + 1) + 1;

  logic          CLK = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_a, base_b, base_c, mem_addr;
  logic          busy, done, mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  matmul_sequencer #(.N(N), .DW(DW), .AW(AW)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .start    (start),
    .base_a   (base_a),
    .base_b   (base_b),
    .base_c   (base_c),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory with synchronous read, plus a bench-side preload port.
  logic [DW-1:0] mem [1 << AW];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_data;
  logic [AW-1:0] wr_addr_q[$];
  int            cyc;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
    end
    if (tb_we) mem[tb_addr] <= tb_data;
  end

  // Mid-cycle observation of strobes and status.
  logic [AW-1:0] rd_addr_q[$];
  int busy_cnt, done_cnt, both_cnt, strobe_cnt;

  always @(negedge CLK) begin
    if (mem_rd) rd_addr_q.push_back(mem_addr);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_rd && mem_wr) both_cnt++;
    if (mem_rd || mem_wr) strobe_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference operands for the current operation.
  logic [DW-1:0] ma[NN];
  logic [DW-1:0] mb[NN];
  logic [DW-1:0] exp_known[NN] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
  int            done_raw;

  function automatic logic [DW-1:0] sentinel(input int idx);
    return 32'hDEAD_0000 + DW'(idx);
  endfunction

  // Preload A, B and a sentinel pattern over C; called at a negedge.
  task automatic load(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW-1:0] bc);
    tb_we = 1'b1;
    for (int idx = 0; idx < NN; idx++) begin
      tb_addr = ba + AW'(idx); tb_data = ma[idx]; @(negedge CLK);
    end
    for (int idx = 0; idx < NN; idx++) begin
      tb_addr = bb + AW'(idx); tb_data = mb[idx]; @(negedge CLK);
    end
    for (int idx = 0; idx < NN; idx++) begin
      tb_addr = bc + AW'(idx); tb_data = sentinel(idx); @(negedge CLK);
    end
    tb_we = 1'b0;
  endtask

  // Run one multiply from a negedge in IDLE; optionally poke start or assert reset mid-run.
  task automatic run_op(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                        input logic [AW-1:0] bc, input int poke_at, input int reset_at,
                        input string name);
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_wr[$];
    logic [DW-1:0] exp_c[NN];
    logic [DW-1:0] acc;
    int s, c, sc0;
    bit got_done, stopped;

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
          acc = acc + ma[i*N+k] * mb[k*N+j];
          exp_rd.push_back(ba + AW'(i*N+k));
          exp_rd.push_back(bb + AW'(k*N+j));
        end
        exp_c[i*N+j] = acc;
        exp_wr.push_back(bc + AW'(i*N+j));
      end
    end

    rd_addr_q.delete(); wr_addr_q.delete();
    busy_cnt = 0; done_cnt = 0; both_cnt = 0; strobe_cnt = 0;
    base_a = ba; base_b = bb; base_c = bc; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    s = cyc;
    got_done = 0; stopped = 0; sc0 = 0;

    for (int t = 0; t < 4 * OPCYC; t++) begin
      c = cyc - s + 1;
      if (c == poke_at) begin
        start = 1'b1; base_a = ~ba; base_b = ~bb; base_c = ~bc;
      end else begin
        start = 1'b0;
      end
      if (c == reset_at) begin
        #2 reset = 1'b1;
        #1 check({name, "_rst_outputs"}, {busy, done, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
        sc0 = strobe_cnt;
        stopped = 1;
        break;
      end
      if (done) begin
        got_done = 1;
        done_raw = cyc;
        check({name, "_done_cycle"}, c, OPCYC);
        break;
      end
      @(negedge CLK);
    end
    start = 1'b0;

    if (stopped) begin
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      repeat (5) @(negedge CLK);
      check({name, "_no_strobe_after_rst"}, strobe_cnt, sc0);
      check({name, "_no_done"}, done_cnt, 0);
      check({name, "_partial_wr_cnt"}, wr_addr_q.size(), 4);
      for (int idx = 0; idx < NN; idx++) begin
        if (idx < 4) check({name, "_kept_c"}, mem[bc + AW'(idx)], exp_c[idx]);
        else check({name, "_unwritten_c"}, mem[bc + AW'(idx)], sentinel(idx));
      end
    end else begin
      check({name, "_done_seen"}, got_done, 1);
      @(negedge CLK);
      check({name, "_idle_after"}, busy, 0);
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_busy_cnt"}, busy_cnt, OPCYC);
      check({name, "_rd_wr_overlap"}, both_cnt, 0);
      check({name, "_rd_cnt"}, rd_addr_q.size(), exp_rd.size());
      for (int idx = 0; idx < exp_rd.size(); idx++)
        check({name, "_rd_addr"}, rd_addr_q[idx], exp_rd[idx]);
      check({name, "_wr_cnt"}, wr_addr_q.size(), NN);
      for (int idx = 0; idx < NN; idx++) begin
        check({name, "_wr_addr"}, wr_addr_q[idx], exp_wr[idx]);
        check({name, "_c_val"}, mem[exp_wr[idx]], exp_c[idx]);
      end
    end
  endtask

  task automatic rand_mats();
    for (int idx = 0; idx < NN; idx++) begin
      ma[idx] = $urandom();
      mb[idx] = $urandom();
    end
  endtask

  initial begin
    int prev;
    logic [AW-1:0] ra, rb, rc;
    reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    base_a = '0; base_b = '0; base_c = '0;
    repeat (3) @(negedge CLK);
    check("rst_outputs", {busy, done, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);
    reset = 1'b0;
    @(negedge CLK);
    check("idle_outputs", {busy, done, mem_rd, mem_wr, mem_addr, mem_wdata}, '0);

    // Known product.
    for (int idx = 0; idx < NN; idx++) begin
      ma[idx] = DW'(idx + 1);
      mb[idx] = DW'(9 - idx);
    end
    load(10'd0, 10'd16, 10'd32);
    run_op(10'd0, 10'd16, 10'd32, 0, 0, "known");
    for (int idx = 0; idx < NN; idx++) check("known_literal", mem[32 + idx], exp_known[idx]);

    // Back-to-back: start in the IDLE cycle right after DONE.
    prev = done_raw;
    run_op(10'd0, 10'd16, 10'd32, 0, 0, "b2b");
    check("b2b_done_gap", done_raw - prev, OPCYC + 1);

    // Identity times random B.
    for (int idx = 0; idx < NN; idx++) begin
      ma[idx] = (idx % (N + 1) == 0) ? 32'd1 : 32'd0;
      mb[idx] = $urandom();
    end
    load(10'd40, 10'd60, 10'd80);
    run_op(10'd40, 10'd60, 10'd80, 0, 0, "ident");
    for (int idx = 0; idx < NN; idx++) check("ident_c_eq_b", mem[80 + idx], mb[idx]);

    // All ones: (-1)*(-1) summed three times.
    for (int idx = 0; idx < NN; idx++) begin
      ma[idx] = '1;
      mb[idx] = '1;
    end
    load(10'd100, 10'd120, 10'd140);
    run_op(10'd100, 10'd120, 10'd140, 0, 0, "ones");
    for (int idx = 0; idx < NN; idx++) check("ones_c", mem[140 + idx], 3);

    // C region wraps past the top of memory.
    rand_mats();
    load(10'd200, 10'd220, 10'd1020);
    run_op(10'd200, 10'd220, 10'd1020, 0, 0, "wrap");
    check("wrap_first", wr_addr_q[0], 1020);
    check("wrap_fifth", wr_addr_q[4], 0);
    check("wrap_last", wr_addr_q[8], 4);

    // Start pulse with altered bases while busy must be ignored.
    rand_mats();
    load(10'd300, 10'd320, 10'd340);
    run_op(10'd300, 10'd320, 10'd340, 40, 0, "busy_start");

    // Reset mid-operation, then a clean full run.
    rand_mats();
    load(10'd400, 10'd420, 10'd440);
    run_op(10'd400, 10'd420, 10'd440, 0, 50, "midrst");
    load(10'd400, 10'd420, 10'd440);
    run_op(10'd400, 10'd420, 10'd440, 0, 0, "after_rst");

    // Random operands and bases.
    repeat (4) begin
      rand_mats();
      ra = AW'($urandom_range(0, 99));
      rb = AW'($urandom_range(300, 399));
      rc = AW'($urandom_range(600, 699));
      load(ra, rb, rc);
      run_op(ra, rb, rc, 0, 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
